// File: rtl/ps2_host_tx_if.sv
// Command handshake and PS/2 pad signals for the host-to-device transmitter.
// The master side issues commands and models the pads; the slave side is the transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocks out one byte
// with odd parity on device clock falling edges, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  bus
);

  localparam int CNT_MAX  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TCNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RTS_LOAD     = CNT_W'(RTS_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST    = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_RELEASE
  } state_t;

  // Pad synchronisers: bit 0 = clock, bit 1 = data. Reset to the idle-high bus level.
  logic [1:0] pad_in;
  logic [1:0] meta_reg, sync_reg, hist_reg;
  logic       clk_sync, data_sync, clk_fall;

  assign pad_in = {bus.ps2_data_in, bus.ps2_clk_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
      hist_reg <= 2'b11;
    end else begin
      meta_reg <= pad_in;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
    end
  end

  assign clk_sync  = sync_reg[0];
  assign data_sync = sync_reg[1];
  assign clk_fall  = hist_reg[0] & ~sync_reg[0];

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
  logic [3:0]        bitidx_reg, bitidx_next;
  logic [7:0]        data_reg, data_next;
  logic              parity_reg, parity_next;
  logic              clk_oe_reg, clk_oe_next;
  logic              data_oe_reg, data_oe_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              timed_out;

  assign timed_out = (tcnt_reg == TCNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      tcnt_reg    <= '0;
      bitidx_reg  <= '0;
      data_reg    <= '0;
      parity_reg  <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      tcnt_reg    <= tcnt_next;
      bitidx_reg  <= bitidx_next;
      data_reg    <= data_next;
      parity_reg  <= parity_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tcnt_next    = tcnt_reg;
    bitidx_next  = bitidx_reg;
    data_next    = data_reg;
    parity_next  = parity_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A request coinciding with a completion pulse is dropped, not deferred.
        if (bus.tx_start && !done_reg && !err_reg) begin
          data_next    = bus.tx_data;
          parity_next  = ~^bus.tx_data;
          cnt_next     = INHIBIT_LOAD;
          clk_oe_next  = 1'b1;
          data_oe_next = 1'b0;
          state_next   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_reg == '0) begin
          cnt_next     = RTS_LOAD;
          data_oe_next = 1'b1;
          state_next   = ST_RTS;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      ST_RTS: begin
        if (cnt_reg == '0) begin
          clk_oe_next = 1'b0;
          bitidx_next = '0;
          tcnt_next   = '0;
          state_next  = ST_SEND;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      ST_SEND: begin
        if (clk_fall) begin
          tcnt_next   = '0;
          bitidx_next = bitidx_reg + 4'd1;
          if (bitidx_reg < 4'd8) begin
            data_oe_next = ~data_reg[bitidx_reg[2:0]];
          end else if (bitidx_reg == 4'd8) begin
            data_oe_next = ~parity_reg;
          end else begin
            data_oe_next = 1'b0;
            state_next   = ST_ACK;
          end
        end else if (timed_out) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          tcnt_next = '0;
          if (!data_sync) begin
            state_next = ST_RELEASE;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (timed_out) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (clk_sync && data_sync) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (clk_fall) begin
          tcnt_next = '0;
        end else if (timed_out) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end else begin
          tcnt_next = tcnt_reg + TCNT_W'(1);
        end
      end

      default: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  assign bus.tx_busy     = (state_reg != ST_IDLE);
  assign bus.tx_done     = done_reg;
  assign bus.tx_err      = err_reg;
  assign bus.ps2_clk_oe  = clk_oe_reg;
  assign bus.ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device that clocks the
// frame in, captures it on rising edges and compares it with a frame model.
module tb_ps2_host_tx;
  localparam int INH  = 40;
  localparam int RTS  = 8;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if ifc ();

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  assign ifc.ps2_clk_in  = ~ifc.ps2_clk_oe & dev_clk;
  assign ifc.ps2_data_in = ~ifc.ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;
  logic [10:0] cap;

  // Activity monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (ifc.tx_done) done_cnt++;
    if (ifc.tx_err) err_cnt++;
    if (ifc.tx_done && ifc.tx_err) both_cnt++;
    if (ifc.ps2_clk_oe && !ifc.ps2_data_oe) inh_cnt++;
    if (ifc.ps2_clk_oe && ifc.ps2_data_oe) rts_cnt++;
  end

  // Wire order: start 0, d[0..7], odd parity, stop 1.
  function automatic logic [10:0] expect_frame(input logic [7:0] d);
    logic p;
    p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; both_cnt = 0; inh_cnt = 0; rts_cnt = 0;
  endtask

  // Device side: waits for request-to-send, clocks 10 bits, then the ACK clock.
  // stop_at >= 0 returns early with the clock held low during that bit.
  task automatic dev_frame(input bit give_ack, input int stop_at);
    int n = 0;
    cap = '1;
    while (!(ifc.ps2_clk_oe == 1'b0 && ifc.ps2_data_oe == 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL rts_wait: no request-to-send seen within %0d cycles", n);
      return;
    end
    repeat (HALF) @(negedge clk);
    cap[0] = ifc.ps2_data_in;
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      if (k == stop_at) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      cap[k+1] = ifc.ps2_data_in;
      repeat (HALF) @(negedge clk);
    end
    if (give_ack) dev_data = 1'b0;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    clear_mon();
    ifc.tx_data  = d;
    ifc.tx_start = 1'b1;
    @(negedge clk);
    ifc.tx_start = 1'b0;
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (done_cnt + err_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt + err_cnt == 0) begin
      checks++; errors++;
      $display("FAIL pulse_wait: no done/err within %0d cycles", n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    ifc.tx_data = 8'h00;
    ifc.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifc.tx_busy); end
    checks++; if ({ifc.tx_done, ifc.tx_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {ifc.tx_done, ifc.tx_err}); end
    checks++; if ({ifc.ps2_clk_oe, ifc.ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe got %b want 00", {ifc.ps2_clk_oe, ifc.ps2_data_oe}); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", ifc.tx_busy); end
  endtask

  task automatic test_commands();
    logic [7:0] list[$];
    list = '{8'hF4, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) list.push_back(8'($urandom));
    foreach (list[i]) begin
      issue(list[i]);
      dev_frame(1'b1, -1);
      wait_pulse();
      $display("cmd %02h wire %03h done %0d err %0d inh %0d rts %0d", list[i], cap, done_cnt, err_cnt, inh_cnt, rts_cnt);
      checks++; if (cap !== expect_frame(list[i])) begin errors++; $display("FAIL frame_%02h got %03h want %03h", list[i], cap, expect_frame(list[i])); end
      checks++; if (inh_cnt !== INH) begin errors++; $display("FAIL inhibit_len got %0d want %0d", inh_cnt, INH); end
      checks++; if (rts_cnt !== RTS) begin errors++; $display("FAIL rts_len got %0d want %0d", rts_cnt, RTS); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL done_pulse got %0d want 1", done_cnt); end
      checks++; if (err_cnt !== 0 || both_cnt !== 0) begin errors++; $display("FAIL err_pulse got %0d/%0d want 0/0", err_cnt, both_cnt); end
      checks++; if ({ifc.tx_busy, ifc.ps2_clk_oe, ifc.ps2_data_oe} !== 3'b000) begin errors++; $display("FAIL after_done got %b want 000", {ifc.tx_busy, ifc.ps2_clk_oe, ifc.ps2_data_oe}); end
    end
  endtask

  task automatic test_no_ack();
    logic [7:0] d = 8'($urandom);
    issue(d);
    dev_frame(1'b0, -1);
    wait_pulse();
    $display("noack %02h wire %03h done %0d err %0d", d, cap, done_cnt, err_cnt);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL noack_err got %0d want 1", err_cnt); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL noack_done got %0d want 0", done_cnt); end
    checks++; if ({ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy} !== 3'b000) begin errors++; $display("FAIL noack_lines got %b want 000", {ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy}); end
  endtask

  task automatic test_timeout();
    int n = 0;
    issue(8'hF4);
    while (!(ifc.ps2_clk_oe == 1'b0 && ifc.ps2_data_oe == 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!(ifc.tx_err || ifc.tx_done) && n < 600) begin
      @(negedge clk);
      n++;
    end
    $display("timeout err after %0d cycles", n);
    checks++; if (n < TMO - 3 || n > TMO + 3) begin errors++; $display("FAIL timeout_latency got %0d want %0d+-3", n, TMO); end
    repeat (4) @(negedge clk);
    checks++; if (err_cnt !== 1 || done_cnt !== 0) begin errors++; $display("FAIL timeout_pulses got err %0d done %0d want 1 0", err_cnt, done_cnt); end
    checks++; if ({ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy} !== 3'b000) begin errors++; $display("FAIL timeout_lines got %b want 000", {ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy}); end
  endtask

  task automatic test_busy_ignore();
    issue(8'hF4);
    repeat (5) @(negedge clk);
    ifc.tx_data  = 8'hAA;
    ifc.tx_start = 1'b1;
    @(negedge clk);
    ifc.tx_start = 1'b0;
    dev_frame(1'b1, -1);
    wait_pulse();
    $display("busy_ignore wire %03h done %0d", cap, done_cnt);
    checks++; if (cap !== expect_frame(8'hF4)) begin errors++; $display("FAIL busy_frame got %03h want %03h", cap, expect_frame(8'hF4)); end
    repeat (20) @(negedge clk);
    checks++; if ({ifc.tx_busy, ifc.ps2_clk_oe} !== 2'b00) begin errors++; $display("FAIL no_queue got %b want 00", {ifc.tx_busy, ifc.ps2_clk_oe}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1 = 8'($urandom);
    logic [7:0] d2 = 8'($urandom);
    int n = 0;
    issue(d1);
    dev_frame(1'b1, -1);
    while (ifc.tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ifc.tx_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b want 1", ifc.tx_done); end
    ifc.tx_data  = d2;
    ifc.tx_start = 1'b1;
    @(negedge clk);
    ifc.tx_start = 1'b0;
    checks++; if (ifc.tx_busy !== 1'b0) begin errors++; $display("FAIL start_in_done_cycle busy got %b want 0", ifc.tx_busy); end
    clear_mon();
    ifc.tx_start = 1'b1;
    @(negedge clk);
    ifc.tx_start = 1'b0;
    checks++; if (ifc.tx_busy !== 1'b1) begin errors++; $display("FAIL start_next_cycle busy got %b want 1", ifc.tx_busy); end
    dev_frame(1'b1, -1);
    wait_pulse();
    $display("b2b %02h then %02h wire %03h inh %0d done %0d", d1, d2, cap, inh_cnt, done_cnt);
    checks++; if (cap !== expect_frame(d2)) begin errors++; $display("FAIL b2b_frame got %03h want %03h", cap, expect_frame(d2)); end
    checks++; if (inh_cnt !== INH || done_cnt !== 1) begin errors++; $display("FAIL b2b_inhibit got inh %0d done %0d want %0d 1", inh_cnt, done_cnt, INH); end
  endtask

  task automatic test_reset_mid();
    issue(8'hF4);
    dev_frame(1'b1, 4);
    #1 reset = 1'b1;
    #1;
    $display("reset_mid lines clk_oe %b data_oe %b busy %b", ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy);
    checks++; if ({ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy} !== 3'b000) begin errors++; $display("FAIL async_reset got %b want 000", {ifc.ps2_clk_oe, ifc.ps2_data_oe, ifc.tx_busy}); end
    @(negedge clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL reset_no_pulse got done %0d err %0d want 0 0", done_cnt, err_cnt); end
    issue(8'hF6);
    dev_frame(1'b1, -1);
    wait_pulse();
    $display("after reset cmd f6 wire %03h done %0d", cap, done_cnt);
    checks++; if (cap !== expect_frame(8'hF6)) begin errors++; $display("FAIL f6_frame got %03h want %03h", cap, expect_frame(8'hF6)); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL f6_done got done %0d err %0d want 1 0", done_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_no_ack();
    test_timeout();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xF4 "enable reporting", 0xFF "reset") to the mouse or keyboard using the standard inhibit/request-to-send sequence.
- Checks the device's ACK bit at the end of the frame.
- Sits beside ps2_support on the mouse port in clock domain cpu_clk. At top level it drives the open-drain ms_ps2_clk/ms_ps2_data pads.
- Exposes tx_busy so the receive path can ignore frames while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000, clocks the host holds PS/2 clock low before request-to-send (≥100 us).
- RTS_CYCLES, 50, clocks data and clock are both held low before clock is released.
- TIMEOUT_CYCLES, 750000, maximum clocks allowed between device clock falling edges, or while waiting for bus release (15 ms).

Ports:
- clk  in  1  block clock (cpu_clk)
- reset  in  1  asynchronous, active-high reset
- tx_data  in  8  command byte; sampled on the accepting cycle
- tx_start  in  1  one-cycle request; accepted only when tx_busy=0
- tx_busy  out  1  high from the cycle after acceptance until completion or abort
- tx_done  out  1  one-cycle pulse: frame sent and ACK received
- tx_err  out  1  one-cycle pulse: timeout or missing ACK
- ps2_clk_in  in  1  raw PS/2 clock pad input
- ps2_data_in  in  1  raw PS/2 data pad input
- ps2_clk_oe  out  1  1 = pull clock pad low; 0 = release (pad = oe ? 0 : z)
- ps2_data_oe  out  1  1 = pull data pad low; 0 = release

Behaviour:
- Reset (async, immediate): state=IDLE; tx_busy=0, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0; counters and bit index cleared. Asserting reset mid-frame releases both lines immediately; no done/err pulse is issued.
- Input sync: each pad input passes through 2 flops plus a history flop. A falling edge of the clock is detected as hist=1 & sync=0, 3 cycles after the pin transition.
- Frame contents, in transmit order:
  - start bit = 0
  - d[0..7], LSB first
  - odd parity P = ~^d
  - stop bit = 1 (data released)
- State machine:
  - IDLE: tx_start & !busy → latch byte, compute parity, load cnt=INHIBIT_CYCLES-1 → INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0; when cnt=0 → RTS with cnt=RTS_CYCLES-1.
  - RTS: clk_oe=1, data_oe=1 (start bit presented); when cnt=0 → SEND with clk_oe=0, bitidx=0, tcnt=0.
  - SEND: data_oe keeps its last value until a falling edge. On each falling edge:
    - bitidx 0..7: data_oe = ~d[bitidx]
    - bitidx 8: data_oe = ~P
    - bitidx 9: data_oe = 0 (stop bit)
    - bitidx increments after each edge; after the 10th edge → ACK.
  - ACK: on the next falling edge sample data_sync. 0 → RELEASE. 1 → tx_err pulse, go to IDLE.
  - RELEASE: wait until clk_sync=1 and data_sync=1, then pulse tx_done → IDLE.
- Timeout: tcnt counts in SEND, ACK and RELEASE and clears on every falling edge. When tcnt reaches TIMEOUT_CYCLES-1: both oe=0, tx_err pulse, → IDLE.
- tx_busy=1 in every state except IDLE. tx_start while busy is ignored; there is no queueing. tx_done and tx_err never assert together.
- Completion pulses go high in the cycle the FSM returns to IDLE. A tx_start in that same cycle is ignored; a new request is accepted on the next cycle.
- Back-to-back commands: each command performs the full INHIBIT again.
- Widths: cnt and tcnt are sized by $clog2 of their maximum; bitidx is 4 bits.

Test Plan:
- Bench setup: INHIBIT_CYCLES=40, RTS_CYCLES=8, TIMEOUT_CYCLES=400; PS/2 device model with a 20-clock half-period that samples data on rising edges.
- 0xF4 → clock held low 40 cycles, then both lines low 8 cycles. Device captures start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1. Model ACKs → tx_done one cycle, tx_busy low afterward.
- 0xFF → parity 1, stop 1, tx_done. Then 0x00 → parity 1, tx_done.
- Device omits ACK (data high on 11th falling edge) → tx_err pulse, no tx_done, both oe=0.
- Device never clocks after RTS → tx_err exactly 400 cycles after clk_oe deasserts, 3-cycle sync tolerance.
- tx_start with 0xAA while busy sending 0xF4 → ignored; only 0xF4 appears on the wire.
- Reset asserted at bit 4 → both oe=0 and busy=0 asynchronously. A later 0xF6 transmits correctly.
